// File: rtl/br_arb_pkg.sv
// Shared arbiter types: grant-hold FSM state encoding.
package br_arb_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, PKT} br_arb_hold_state_e;
endpackage

// File: rtl/br_enc_bin2onehot.sv
// Binary index to onehot decoder.
module br_enc_bin2onehot #(
  parameter int NumValues = 2,
  localparam int BinWidth = $clog2(NumValues)
) (
  input  logic [BinWidth-1:0]  bin,
  output logic [NumValues-1:0] onehot
);
  for (genvar i = 0; i < NumValues; i++) begin : g_bit
    assign onehot[i] = (bin == BinWidth'(i));
  end
endmodule

// File: rtl/br_arb_rr_hold.sv
// Round-robin arbiter that freezes its grant while the downstream channel stalls.
// Optional packet lock across beats until req_last: define BR_ARB_RR_HOLD_LAST_EN.
module br_arb_rr_hold
  import br_arb_pkg::*;
#(
  parameter int NumRequesters = 2,
  localparam int IdxWidth = $clog2(NumRequesters)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NumRequesters-1:0] req_valid,
  input  logic [NumRequesters-1:0] req_last,
  output logic [NumRequesters-1:0] req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NumRequesters-1:0] grant,
  output logic [IdxWidth-1:0]      grant_idx
);
  br_arb_hold_state_e   state;
  logic [IdxWidth-1:0]  ptr, held_idx;
  logic [IdxWidth-1:0]  win_idx, sel_idx, nxt_ptr, cand_idx;
  logic                 found, sel_vld, pkt_done, hs;
  logic [NumRequesters-1:0] oh;
  int                   cand;

  // Rotating search starting at ptr; first valid requester wins.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NumRequesters; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NumRequesters) cand = cand - NumRequesters;
      cand_idx = IdxWidth'(cand);
      if (!found && req_valid[cand_idx]) begin
        found   = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  assign sel_idx   = (state == IDLE) ? win_idx : held_idx;
  assign sel_vld   = (state == IDLE) ? found : req_valid[held_idx];
  assign out_valid = sel_vld & ~rst;
  assign grant_idx = out_valid ? sel_idx : '0;

  br_enc_bin2onehot #(.NumValues(NumRequesters)) u_oh (
    .bin    (grant_idx),
    .onehot (oh)
  );

  assign grant     = oh & {NumRequesters{out_valid}};
  assign req_ready = grant & {NumRequesters{out_ready}};
  assign hs        = out_valid & out_ready;
  assign nxt_ptr   = (grant_idx == IdxWidth'(NumRequesters - 1)) ? '0 : grant_idx + 1'b1;

`ifdef BR_ARB_RR_HOLD_LAST_EN
  assign pkt_done = req_last[grant_idx];
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign pkt_done    = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      held_idx <= '0;
    end else if (hs) begin
      if (pkt_done) begin
        ptr   <= nxt_ptr;
        state <= IDLE;
      end else begin
        held_idx <= grant_idx;
        state    <= PKT;
      end
    end else if (out_valid) begin
      if (state == IDLE) begin
        held_idx <= grant_idx;
        state    <= HOLD;
      end
    end else if (state == HOLD) begin
      // Held requester withdrew mid-stall: release the lock, keep priority.
      state <= IDLE;
    end
  end

  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_stable: assert property (@(posedge clk) disable iff (rst)
    out_valid && !out_ready |=> !out_valid || $stable(grant));
  a_idx: assert property (@(posedge clk) disable iff (rst)
    int'(grant_idx) < NumRequesters);

  for (genvar i = 0; i < NumRequesters; i++) begin : g_req_hold
    a_req_hold: assert property (@(posedge clk) disable iff (rst)
      !rst && req_valid[i] && !req_ready[i] |=> req_valid[i]);
  end
endmodule

// File: tb/tb_br_arb_rr_hold.sv
// Self-checking bench: N=4 and N=5 arbiters against a rule-level reference model.
module tb_br_arb_rr_hold;
  logic clk = 1'b0, rst = 1'b1, want_rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] rv4 = '0, rl4 = '0, rr4, g4;
  logic       ry4 = 1'b0, ov4;
  logic [1:0] gi4;
  logic [4:0] rv5 = '0, rl5 = '0, rr5, g5;
  logic       ry5 = 1'b0, ov5;
  logic [2:0] gi5;

  br_arb_rr_hold #(.NumRequesters(4)) u4 (
    .clk(clk), .rst(rst), .req_valid(rv4), .req_last(rl4), .req_ready(rr4),
    .out_valid(ov4), .out_ready(ry4), .grant(g4), .grant_idx(gi4));
  br_arb_rr_hold #(.NumRequesters(5)) u5 (
    .clk(clk), .rst(rst), .req_valid(rv5), .req_last(rl5), .req_ready(rr5),
    .out_valid(ov5), .out_ready(ry5), .grant(g5), .grant_idx(gi5));

  int tests = 0, fails = 0;
  // Reference model: priority start, lock flag, lock-from-packet flag, locked index.
  int   mptr[2], midx[2];
  bit   mlock[2], mpkt[2];
  logic [4:0] cv[2], cl[2], eg[2], er[2];
  logic       cr[2], ev[2];
  int         ei[2];
  logic       av;
  int         ai;
  logic [4:0] ag, ar;

  task automatic model_eval(input int d);
    int n = (d == 0) ? 4 : 5;
    logic e = 1'b0;
    int   i = 0;
    if (mlock[d]) begin
      e = cv[d][midx[d]];
      i = midx[d];
    end else begin
      for (int k = 0; k < n; k++) begin
        if (!e && cv[d][(mptr[d] + k) % n]) begin
          e = 1'b1;
          i = (mptr[d] + k) % n;
        end
      end
    end
    if (rst || !e) begin e = 1'b0; i = 0; end
    ev[d] = e;
    ei[d] = i;
    eg[d] = e ? (5'b1 << i) : 5'b0;
    er[d] = cr[d] ? eg[d] : 5'b0;
  endtask

  task automatic drive(input int d, input logic [4:0] v, input logic [4:0] l, input logic r);
    @(negedge clk);
    rst = want_rst;
    cv[d] = v; cl[d] = l; cr[d] = r;
    rv4 = cv[0][3:0]; rl4 = cl[0][3:0]; ry4 = cr[0];
    rv5 = cv[1];      rl5 = cl[1];      ry5 = cr[1];
    #1;
    model_eval(0);
    model_eval(1);
    if (d == 0) begin av = ov4; ai = int'(gi4); ag = {1'b0, g4}; ar = {1'b0, rr4}; end
    else        begin av = ov5; ai = int'(gi5); ag = g5;         ar = rr5;         end
  endtask

  task automatic advance();
    bit last;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mptr[d] = 0; mlock[d] = 0; mpkt[d] = 0; midx[d] = 0;
      end else if (ev[d] && cr[d]) begin
`ifdef BR_ARB_RR_HOLD_LAST_EN
        last = cl[d][ei[d]];
`else
        last = 1'b1;
`endif
        if (last) begin
          mptr[d] = (ei[d] + 1) % ((d == 0) ? 4 : 5);
          mlock[d] = 0; mpkt[d] = 0;
        end else begin
          mlock[d] = 1; mpkt[d] = 1; midx[d] = ei[d];
        end
      end else if (ev[d]) begin
        if (!mlock[d]) begin mlock[d] = 1; mpkt[d] = 0; midx[d] = ei[d]; end
      end else if (mlock[d] && !mpkt[d]) begin
        mlock[d] = 0;
      end
    end
  endtask

  // Completes every pending request on one arbiter so the next scenario starts clean.
  task automatic drain(input int d);
    logic [4:0] v = cv[d];
    int guard = 0;
    while (v != 0 && guard < 40) begin
      drive(d, v, 5'h1f, 1'b1);
      v = v & ~ar;
      advance();
      guard++;
    end
    if (v != 0) begin
      fails++; tests++;
      $display("FAIL drain%0d timeout: pending %b want 0", d, v);
    end
  endtask

  task automatic test_reset();
    want_rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive(0, 5'h0f, 5'h1f, 1'b1);
      tests++;
      if ({av, ag, ar, ai[1:0]} !== 14'h0) begin
        fails++; $display("FAIL reset_outputs: got %b/%h/%h/%0d want 0/0/0/0", av, ag, ar, ai);
      end
      advance();
    end
    want_rst = 1'b0;
    drive(0, 5'h0f, 5'h1f, 1'b1);
    tests++;
    if (ai !== 0 || av !== 1'b1) begin
      fails++; $display("FAIL reset_first_grant: got idx %0d vld %b want 0 1", ai, av);
    end
    advance();
    drain(0);
  endtask

  task automatic test_rr4();
    drive(0, 5'h08, 5'h1f, 1'b1);
    advance();
    for (int c = 0; c < 8; c++) begin
      drive(0, 5'h0f, 5'h1f, 1'b1);
      tests++;
      if (ai !== c % 4 || ar !== (5'b1 << (c % 4))) begin
        fails++; $display("FAIL rr4 cycle %0d: got idx %0d ready %b want %0d", c, ai, ar, c % 4);
      end
      advance();
    end
    drain(0);
  endtask

  task automatic test_wrap5();
    drive(1, 5'h10, 5'h1f, 1'b1);
    tests++;
    if (ai !== 4 || ag !== 5'h10) begin
      fails++; $display("FAIL wrap5_req4: got idx %0d grant %b want 4 10000", ai, ag);
    end
    advance();
    drive(1, 5'h1f, 5'h1f, 1'b1);
    tests++;
    if (ai !== 0) begin
      fails++; $display("FAIL wrap5_next: got idx %0d want 0", ai);
    end
    advance();
    drain(1);
  endtask

  task automatic test_hold();
    logic [4:0] vs[5]  = '{5'h01, 5'h04, 5'h06, 5'h06, 5'h06};
    logic       rs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    int         xs[5]  = '{0, 2, 2, 2, 2};
    for (int c = 0; c < 5; c++) begin
      drive(0, vs[c], 5'h1f, rs[c]);
      tests++;
      if (ai !== xs[c] || ag !== (5'b1 << xs[c]) || ar !== (rs[c] ? ag : 5'h0)) begin
        fails++; $display("FAIL hold step %0d: got idx %0d grant %b ready %b want %0d", c, ai, ag, ar, xs[c]);
      end
      advance();
    end
    drive(0, 5'h02, 5'h1f, 1'b1);
    tests++;
    if (ai !== 1) begin
      fails++; $display("FAIL hold_after: got idx %0d want 1", ai);
    end
    advance();
  endtask

  task automatic test_pkt();
    logic [4:0] vs[4] = '{5'h03, 5'h03, 5'h03, 5'h02};
    logic [4:0] ls[4] = '{5'h00, 5'h00, 5'h01, 5'h02};
`ifdef BR_ARB_RR_HOLD_LAST_EN
    int         xs[4] = '{0, 0, 0, 1};
`else
    int         xs[4] = '{0, 1, 0, 1};
`endif
    drive(0, 5'h08, 5'h1f, 1'b1);
    advance();
    for (int c = 0; c < 4; c++) begin
      drive(0, vs[c], ls[c], 1'b1);
      tests++;
      if (ai !== xs[c] || ai !== ei[0]) begin
        fails++; $display("FAIL pkt beat %0d: got idx %0d want %0d", c, ai, xs[c]);
      end
      advance();
    end
    drain(0);
  endtask

  task automatic test_idle();
    drive(0, 5'h04, 5'h1f, 1'b1);
    advance();
    for (int c = 0; c < 2; c++) begin
      drive(0, 5'h00, 5'h1f, 1'b1);
      tests++;
      if ({av, ag, ar, ai[1:0]} !== 14'h0) begin
        fails++; $display("FAIL idle_outputs: got %b/%h/%h/%0d want 0/0/0/0", av, ag, ar, ai);
      end
      advance();
    end
    drive(0, 5'h0f, 5'h1f, 1'b1);
    tests++;
    if (ai !== 3) begin
      fails++; $display("FAIL idle_ptr_kept: got idx %0d want 3", ai);
    end
    advance();
    drain(0);
  endtask

  task automatic test_reset_hold();
    drive(0, 5'h08, 5'h1f, 1'b0);
    advance();
    drive(0, 5'h0c, 5'h1f, 1'b0);
    tests++;
    if (ai !== 3) begin
      fails++; $display("FAIL rhold_locked: got idx %0d want 3", ai);
    end
    advance();
    want_rst = 1'b1;
    drive(0, 5'h0f, 5'h1f, 1'b1);
    tests++;
    if ({av, ag, ar, ai[1:0]} !== 14'h0) begin
      fails++; $display("FAIL rhold_in_reset: got %b/%h/%h/%0d want 0/0/0/0", av, ag, ar, ai);
    end
    advance();
    want_rst = 1'b0;
    drive(0, 5'h0f, 5'h1f, 1'b1);
    tests++;
    if (ai !== 0) begin
      fails++; $display("FAIL rhold_after: got idx %0d want 0", ai);
    end
    advance();
    drain(0);
  endtask

  task automatic test_random(input int d, input int cycles);
    int n = (d == 0) ? 4 : 5;
    logic [4:0] pend = cv[d];
    logic [4:0] l;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < n; i++) if (!pend[i] && ($urandom % 2) == 0) pend[i] = 1'b1;
      l = 5'($urandom) & ((5'b1 << n) - 5'd1);
      drive(d, pend, l, ($urandom % 4) != 0);
      tests++;
      if ({av, ag, ar} !== {ev[d], eg[d], er[d]} || ai !== ei[d]) begin
        fails++;
        $display("FAIL random%0d cycle %0d: got v%b g%b r%b i%0d want v%b g%b r%b i%0d",
                 d, c, av, ag, ar, ai, ev[d], eg[d], er[d], ei[d]);
      end
      pend = pend & ~ar;
      advance();
    end
    drain(d);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      mptr[d] = 0; midx[d] = 0; mlock[d] = 0; mpkt[d] = 0;
      cv[d] = '0; cl[d] = '0; cr[d] = 1'b0;
    end
    test_reset();
    test_rr4();
    test_wrap5();
    test_hold();
    test_pkt();
    test_idle();
    test_reset_hold();
    test_random(0, 400);
    test_random(1, 400);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
